// File: rtl/alu_control_seq.sv
// alu_control_seq
// Registered ALU-control decoder for the multicycle MIPS core. It decodes
// alu_op/funct/opcode into the ALU control code, and it sequences multi-cycle
// MULT/DIV operations through an iterative mult/div unit.
//
// Ports:
//   clk, reset        rising-edge clock and synchronous active-high reset
//   valid / ready     decode request handshake (accepted on valid & ready)
//   alu_op            00 add, 01 sub, 10 R-type (funct), 11 I-type (opcode)
//   funct, opcode     instruction fields
//   flush             abort an in-progress MULT/DIV
//   alu_ctl, illegal  registered decode result, held until the next accept
//   md_start          1-cycle pulse that starts the mult/div unit
//   md_op             00 none, 01 MULT, 10 DIV
//   md_done           1-cycle pulse when the mult/div operation completes
module alu_control_seq #(
    parameter int ALU_CTL_W   = 3,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [1:0]           alu_op,
    input  logic [5:0]           funct,
    input  logic [5:0]           opcode,
    input  logic                 flush,
    output logic                 ready,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 illegal,
    output logic                 md_start,
    output logic [1:0]           md_op,
    output logic                 md_done
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] counter;
    logic [2:0]       dec_ctl;
    logic             dec_ill;
    logic [1:0]       dec_md;
    logic             accept;
    logic             md_accept;

    // Combinational decode of the current request fields.
    always_comb begin
        dec_ctl = 3'b000;
        dec_ill = 1'b0;
        dec_md  = MD_NONE;
        unique case (alu_op)
            2'b00: dec_ctl = 3'b001;
            2'b01: dec_ctl = 3'b010;
            2'b10: begin
                case (funct)
                    6'h20:         dec_ctl = 3'b001;
                    6'h22:         dec_ctl = 3'b010;
                    6'h24:         dec_ctl = 3'b011;
                    6'h2a:         dec_ctl = 3'b111;
                    6'h08, 6'h05:  dec_ctl = 3'b000;
                    6'h18:         dec_md  = MD_MULT;
                    6'h1a:         dec_md  = MD_DIV;
                    default:       dec_ill = 1'b1;
                endcase
            end
            default: begin
                case (opcode)
                    6'h08:   dec_ctl = 3'b001;
                    6'h0c:   dec_ctl = 3'b011;
                    6'h0a:   dec_ctl = 3'b111;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    assign ready     = (state == IDLE);
    assign md_done   = (state == DONE);
    assign accept    = valid & ready;
    assign md_accept = accept & (dec_md != MD_NONE);

    // The next-state logic checks flush before the counter, so an abort
    // always wins over a completion in the same cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (md_accept) state_nx = BUSY;
            BUSY: begin
                if (flush)              state_nx = IDLE;
                else if (counter == '0) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            alu_ctl  <= '0;
            illegal  <= 1'b0;
            md_start <= 1'b0;
            md_op    <= MD_NONE;
        end else begin
            state    <= state_nx;
            md_start <= md_accept;
            if (accept) begin
                alu_ctl <= ALU_CTL_W'(dec_ctl);
                illegal <= dec_ill;
            end
            if (md_accept) begin
                md_op   <= dec_md;
                // Loading N-1 keeps BUSY for N cycles and gives the DONE
                // cycle as cycle N+1 after acceptance.
                counter <= (dec_md == MD_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                               : CNT_W'(DIV_CYCLES - 1);
            end else if (state == BUSY && counter != '0) begin
                counter <= counter - 1'b1;
            end
            if ((state == BUSY && flush) || state == DONE)
                md_op <= MD_NONE;
        end
    end

endmodule
